// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared types and constants for the quantisation-table sequencer
// Purpose: block geometry, data/multiplier widths, index and multiplier types,
// table-select enum and the luma-count clamp helper.
package flow_pkg;

  localparam int BLK_COEFS = 64;
  localparam int DATA_W    = 16;
  localparam int MULT_W    = 10;
  localparam int RADDR_W   = 7;   // {table, index}

  typedef logic [5:0]        qidx_t;
  typedef logic [MULT_W-1:0] qmult_t;

  typedef enum logic {
    TAB_LUMA   = 1'b0,
    TAB_CHROMA = 1'b1
  } tab_sel_t;

  // Luma blocks per MCU are limited to 1..4.
  function automatic logic [2:0] clamp_lb(input logic [2:0] v);
    logic [2:0] r;
    r = v;
    if (v == 3'd0) r = 3'd1;
    else if (v > 3'd4) r = 3'd4;
    return r;
  endfunction

endpackage

// File: rtl/flow_qtab_ram.sv
// rtl/flow_qtab_ram.sv - two 64-entry multiplier tables, one write port, N read ports
// Purpose: luma/chroma multiplier storage.
// Ports:
//   clk              clock
//   we/tab/waddr/wdata  write strobe, table select, entry index, value
//   raddr            N packed {table, index} read addresses
//   rdata            N packed multipliers, combinational
// A read of an entry being written in the same cycle returns the old value,
// since the array only updates at the clock edge.
module flow_qtab_ram
  import flow_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  tab,
  input  logic [5:0]            waddr,
  input  logic [MULT_W-1:0]     wdata,
  input  logic [N*RADDR_W-1:0]  raddr,
  output logic [N*MULT_W-1:0]   rdata
);

  qmult_t mem [0:2*BLK_COEFS-1];

  always_ff @(posedge clk) begin
    if (we) mem[{tab, waddr}] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N; i++) begin
      rdata[i*MULT_W +: MULT_W] = mem[raddr[i*RADDR_W +: RADDR_W]];
    end
  end

endmodule

// File: rtl/flow_qtab_seq.sv
// rtl/flow_qtab_seq.sv - quantisation-table sequencer feeding the multiplier stage
// Purpose: tracks coefficient position and MCU block index, looks up per-lane
// multipliers and registers them aligned with the data and flags.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   en, in_valid            beat accepted when both high
//   in_data                 N x 16 coefficients, lane i = index pos+i
//   in_sob/in_eob/in_sof    block / frame markers
//   cfg_we/cfg_tab/cfg_addr/cfg_wdata  table write port
//   cfg_luma_blocks         luma blocks per MCU, sampled on sof
//   out_valid/out_data/out_mult/out_sob/out_eob/out_sof  registered beat
//   out_err                 sticky protocol error
module flow_qtab_seq
  import flow_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [N*DATA_W-1:0]  in_data,
  input  logic                 in_sob,
  input  logic                 in_eob,
  input  logic                 in_sof,
  input  logic                 cfg_we,
  input  logic                 cfg_tab,
  input  logic [5:0]           cfg_addr,
  input  logic [MULT_W-1:0]    cfg_wdata,
  input  logic [2:0]           cfg_luma_blocks,
  output logic                 out_valid,
  output logic [N*DATA_W-1:0]  out_data,
  output logic [N*MULT_W-1:0]  out_mult,
  output logic                 out_sob,
  output logic                 out_eob,
  output logic                 out_sof,
  output logic                 out_err
);

  localparam qidx_t N_IDX    = qidx_t'(N);
  localparam qidx_t LAST_IDX = qidx_t'(BLK_COEFS - N);

  qidx_t      pos;
  logic [2:0] blk;
  logic [2:0] lb;
  logic       prev_eob;

  logic                 acc;
  logic                 sob_eff;
  qidx_t                idx0;
  qidx_t                pos_next;
  logic [2:0]           blk_cur;
  logic [2:0]           lb_use;
  logic [2:0]           blk_inc;
  logic [2:0]           blk_next;
  tab_sel_t             sel;
  logic                 err_now;
  logic [N*RADDR_W-1:0] raddr;
  logic [N*MULT_W-1:0]  rdata;

  always_comb begin
    acc     = in_valid & en;
    sob_eff = in_sob | in_sof;           // sof always starts a block
    idx0    = sob_eff ? '0 : pos;
    blk_cur = in_sof ? 3'd0 : blk;
    // On a sof beat the freshly sampled luma count already applies.
    lb_use  = in_sof ? clamp_lb(cfg_luma_blocks) : lb;
    sel     = (blk_cur < lb_use) ? TAB_LUMA : TAB_CHROMA;
    blk_inc = blk_cur + 3'd1;
    // MCU holds lb luma + 2 chroma blocks; wrap after the last chroma block.
    blk_next = in_eob ? ((blk_inc == lb_use + 3'd2) ? 3'd0 : blk_inc) : blk_cur;
    pos_next = in_eob ? '0 : idx0 + N_IDX;
    err_now  = acc & ((in_eob & (idx0 != LAST_IDX)) |
                      (in_sob & ~in_sof & (pos != '0)) |
                      (~sob_eff & (pos == '0) & prev_eob));
    raddr = '0;
    for (int i = 0; i < N; i++) begin
      raddr[i*RADDR_W +: RADDR_W] = {sel, idx0 + qidx_t'(i)};
    end
  end

  flow_qtab_ram #(.N(N)) u_ram (
    .clk   (clk),
    .we    (cfg_we),
    .tab   (cfg_tab),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos       <= '0;
      blk       <= '0;
      lb        <= 3'd1;
      prev_eob  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mult  <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
      out_sof   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= acc;
      if (acc) begin
        pos      <= pos_next;
        blk      <= blk_next;
        prev_eob <= in_eob;
        if (in_sof) lb <= lb_use;
        out_data <= in_data;
        out_mult <= rdata;
        out_sob  <= in_sob;
        out_eob  <= in_eob;
        out_sof  <= in_sof;
      end
      if (err_now) out_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_qtab_seq.sv
// tb/tb_flow_qtab_seq.sv - directed self-checking bench for flow_qtab_seq
module tb_flow_qtab_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_sob, in_eob, in_sof;
  logic        cfg_we;
  logic        cfg_tab;
  logic [5:0]  cfg_addr;
  logic [9:0]  cfg_wdata;
  logic [2:0]  cfg_luma_blocks;
  logic        out_valid;
  logic [31:0] out_data;
  logic [19:0] out_mult;
  logic        out_sob, out_eob, out_sof, out_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] lt [64];
  logic [9:0] ct [64];

  always #5 clk = ~clk;

  flow_qtab_seq #(.N(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_sob          (in_sob),
    .in_eob          (in_eob),
    .in_sof          (in_sof),
    .cfg_we          (cfg_we),
    .cfg_tab         (cfg_tab),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_luma_blocks (cfg_luma_blocks),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_mult        (out_mult),
    .out_sob         (out_sob),
    .out_eob         (out_eob),
    .out_sof         (out_sof),
    .out_err         (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] shadow(input logic t, input int idx);
    return t ? ct[idx] : lt[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic t, input int addr, input logic [9:0] v);
    cfg_we = 1'b1; cfg_tab = t; cfg_addr = 6'(addr); cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
    if (t) ct[addr] = v; else lt[addr] = v;
  endtask

  task automatic gap();
    int r;
    r = $urandom_range(0, 2);
    in_valid = (r == 1);
    en       = (r == 2);
    tick();
    check("gap_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // One accepted beat with lane-0 index idx; optional colliding write of chroma[10]=999.
  task automatic one_beat(input int idx, input logic t, input logic sob, input logic eob,
                          input logic sof, input bit do_wr);
    logic [31:0] d;
    d = {16'(idx * 7 + 3), 16'(idx * 5 + 1)};
    in_valid = 1'b1; en = 1'b1;
    in_data = d; in_sob = sob; in_eob = eob; in_sof = sof;
    if (do_wr) begin
      cfg_we = 1'b1; cfg_tab = 1'b1; cfg_addr = 6'd10; cfg_wdata = 10'd999;
    end
    tick();
    check("valid", {31'd0, out_valid}, 32'd1);
    check("mult", {12'd0, out_mult}, {12'd0, shadow(t, idx + 1), shadow(t, idx)});
    check("data", out_data, d);
    check("flags", {29'd0, out_sob, out_eob, out_sof}, {29'd0, sob, eob, sof});
    if (do_wr) begin
      cfg_we = 1'b0;
      ct[10] = 10'd999;
    end
    in_valid = 1'b0; en = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_block(input logic sof, input logic t, input bit gaps, input int wr_beat);
    for (int b = 0; b < 32; b++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) if ($urandom_range(0, 1) == 1) gap();
      end
      one_beat(2 * b, t, b == 0, b == 31, sof && b == 0, b == wr_beat);
    end
  endtask

  // Expected table order per block, hand-derived from the MCU layout.
  logic seq_lb2 [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  logic seq_lb0 [6] = '{0, 1, 1, 0, 1, 1};

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    cfg_we = 1'b0; cfg_tab = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_luma_blocks = 3'd1;
    tick(); tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    check("rst_mult", {12'd0, out_mult}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_flags", {29'd0, out_sob, out_eob, out_sof}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 64; k++) begin
      wr(1'b0, k, 10'(k + 1));
      wr(1'b1, k, 10'(200 + k));
    end

    // single luma block
    send_block(1'b1, 1'b0, 1'b0, -1);
    tick();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("err_clean1", {31'd0, out_err}, 32'd0);

    // two luma blocks per MCU
    cfg_luma_blocks = 3'd2;
    for (int m = 0; m < 8; m++) send_block(m == 0, seq_lb2[m], 1'b0, -1);
    // zero clamps to one luma block; change only applies at sof
    cfg_luma_blocks = 3'd0;
    for (int m = 0; m < 6; m++) send_block(m == 0, seq_lb0[m], 1'b0, -1);
    check("err_clean2", {31'd0, out_err}, 32'd0);

    // random gaps from en / in_valid
    cfg_luma_blocks = 3'd1;
    send_block(1'b1, 1'b0, 1'b1, -1);
    send_block(1'b0, 1'b1, 1'b1, -1);
    check("err_clean3", {31'd0, out_err}, 32'd0);

    // write/read collision on chroma[10]
    send_block(1'b1, 1'b0, 1'b0, -1);
    send_block(1'b0, 1'b1, 1'b0, 5);
    send_block(1'b0, 1'b1, 1'b0, -1);
    check("err_clean4", {31'd0, out_err}, 32'd0);

    // early eob at index 30
    for (int b = 0; b < 15; b++) one_beat(2 * b, 1'b0, b == 0, 1'b0, b == 0, 1'b0);
    check("err_before_eob", {31'd0, out_err}, 32'd0);
    one_beat(30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("err_eob30", {31'd0, out_err}, 32'd1);
    for (int b = 0; b < 8; b++) one_beat(2 * b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    one_beat(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("err_sticky", {31'd0, out_err}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("err_cleared", {31'd0, out_err}, 32'd0);

    // reset mid-block
    for (int b = 0; b < 10; b++) one_beat(2 * b, 1'b0, b == 0, 1'b0, b == 0, 1'b0);
    rst_n = 1'b0; in_valid = 1'b1; en = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_mult", {12'd0, out_mult}, 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0; en = 1'b0;
    send_block(1'b1, 1'b0, 1'b0, -1);
    send_block(1'b0, 1'b1, 1'b0, -1);
    check("err_final", {31'd0, out_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
